// File: rtl/nibble_chain_adder.sv
// nibble_chain_adder
//   Sequential multi-nibble adder. Operand pairs arrive one nibble per transfer,
//   least-significant nibble first, over a valid/ready handshake. A single 4-bit
//   add-with-carry datapath is reused for every nibble, with the carry chained
//   through a register. The full sum and the carry-out of the top nibble are
//   presented on a valid/ready output and held until the consumer takes them.
//
// Parameters
//   NIBBLES    nibbles per transaction (1..8); result width is 4*NIBBLES
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   abort      discard the partial transaction while collecting
//   in_valid   operand nibble pair present
//   in_ready   block accepts a nibble pair this cycle
//   in_x       operand X nibble
//   in_y       operand Y nibble
//   out_valid  result available
//   out_ready  consumer takes the result this cycle
//   out_sum    registered sum (carry-out not folded in)
//   out_carry  registered carry-out of the most-significant nibble
module nibble_chain_adder #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_x,
   input  logic [3:0]           in_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_sum,
   output logic                 out_carry
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

   typedef enum logic [0:0] {StCollect, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    partial_q, partial_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic [4:0]      nib_sum;

   // Shared 4-bit add-with-carry datapath.
   assign nib_sum = {1'b0, in_x} + {1'b0, in_y} + {4'b0000, carry_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StCollect;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         partial_q <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         partial_q <= partial_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      partial_d = partial_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      // in_ready is gated by rst so the source sees no acceptance during reset.
      in_ready  = (state_q == StCollect) && !rst;
      out_valid = (state_q == StDone);

      unique case (state_q)
         StCollect: begin
            if (abort) begin
               cnt_d     = '0;
               carry_d   = 1'b0;
               partial_d = '0;
            end else if (in_valid && in_ready) begin
               partial_d[4*cnt_q +: 4] = nib_sum[3:0];
               carry_d                 = nib_sum[4];
               if (cnt_q == LastCnt) begin
                  sum_d   = partial_d;
                  cout_d  = nib_sum[4];
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            // Result held; in_valid and abort are ignored until taken.
            if (out_ready) begin
               state_d   = StCollect;
               cnt_d     = '0;
               carry_d   = 1'b0;
               partial_d = '0;
            end
         end
         default: state_d = StCollect;
      endcase
   end

   assign out_sum   = sum_q;
   assign out_carry = cout_q;

endmodule

// File: tb/tb_nibble_chain_adder.sv
// Bench for nibble_chain_adder: a NIBBLES=4 instance and a NIBBLES=1 instance.
module tb_nibble_chain_adder;

   logic        clk;
   logic        rst;
   logic        abort;
   logic        in_valid, in_ready;
   logic [3:0]  in_x, in_y;
   logic        out_valid, out_ready;
   logic [15:0] out_sum;
   logic        out_carry;

   logic        abort1;
   logic        in_valid1, in_ready1;
   logic [3:0]  in_x1, in_y1;
   logic        out_valid1, out_ready1;
   logic [3:0]  out_sum1;
   logic        out_carry1;

   int total = 0;
   int bad   = 0;
   logic [15:0] prev_sum;

   nibble_chain_adder #(.NIBBLES(4)) u_dut4 (
      .clk(clk), .rst(rst), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry)
   );

   nibble_chain_adder #(.NIBBLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .abort(abort1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_x(in_x1), .in_y(in_y1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_sum(out_sum1), .out_carry(out_carry1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] sum;
      logic        carry;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Feed one 16-bit operand pair, LS nibble first, with optional idle gaps.
   task automatic feed(input logic [15:0] x, input logic [15:0] y, input int gap_max,
                       input bit chk_ripple);
      for (int i = 0; i < 4; i++) begin
         int gaps;
         int n;
         gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
         for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_x = 4'($urandom);
            in_y = 4'($urandom);
            step();
         end
         in_x = x[4*i +: 4];
         in_y = y[4*i +: 4];
         in_valid = 1'b1;
         n = 0;
         while (!in_ready && n < 20) begin
            step();
            n++;
         end
         chk("in_ready_before_accept", 32'(in_ready), 32'd1);
         chk("out_valid_while_collect", 32'(out_valid), 32'd0);
         if (i == 3) chk("out_sum_holds_prev", 32'(out_sum), 32'(prev_sum));
         step();
         if (chk_ripple) chk("ripple_carry_reg", 32'(u_dut4.carry_q), 32'd1);
      end
      in_valid = 1'b0;
   endtask

   // Full transaction against the arithmetic model, then release with out_ready.
   task automatic run_txn(input logic [15:0] x, input logic [15:0] y, input int gap_max,
                          input int hold, input bit chk_ripple);
      logic [16:0] ref_full;
      ref_full = {1'b0, x} + {1'b0, y};
      out_ready = (hold == 0);
      feed(x, y, gap_max, chk_ripple);
      chk("out_valid_after_last", 32'(out_valid), 32'd1);
      chk("out_sum", 32'(out_sum), 32'(ref_full[15:0]));
      chk("out_carry", 32'(out_carry), 32'(ref_full[16]));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_x = 4'($urandom);
         in_y = 4'($urandom);
         abort = h[0];
         step();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_sum", 32'(out_sum), 32'(ref_full[15:0]));
         chk("bp_out_carry", 32'(out_carry), 32'(ref_full[16]));
      end
      in_valid = 1'b0;
      abort = 1'b0;
      out_ready = 1'b1;
      step();
      chk("out_valid_drops", 32'(out_valid), 32'd0);
      chk("in_ready_returns", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      prev_sum = ref_full[15:0];
   endtask

   task automatic run_txn1(input logic [3:0] x, input logic [3:0] y);
      logic [4:0] ref_full;
      ref_full = {1'b0, x} + {1'b0, y};
      in_x1 = x;
      in_y1 = y;
      in_valid1 = 1'b1;
      chk("n1_in_ready", 32'(in_ready1), 32'd1);
      chk("n1_out_valid_before", 32'(out_valid1), 32'd0);
      step();
      in_valid1 = 1'b0;
      chk("n1_out_valid", 32'(out_valid1), 32'd1);
      chk("n1_out_sum", 32'(out_sum1), 32'(ref_full[3:0]));
      chk("n1_out_carry", 32'(out_carry1), 32'(ref_full[4]));
      out_ready1 = 1'b1;
      step();
      chk("n1_out_valid_drops", 32'(out_valid1), 32'd0);
      out_ready1 = 1'b0;
   endtask

   vec_t tbl[5];

   initial begin
      tbl[0] = '{x: 16'h1234, y: 16'h0F0F, sum: 16'h2143, carry: 1'b0};
      tbl[1] = '{x: 16'hFFFF, y: 16'h0001, sum: 16'h0000, carry: 1'b1};
      tbl[2] = '{x: 16'hF97D, y: 16'h9F24, sum: 16'h98A1, carry: 1'b1};
      tbl[3] = '{x: 16'h0001, y: 16'h0001, sum: 16'h0002, carry: 1'b0};
      tbl[4] = '{x: 16'h8000, y: 16'h8000, sum: 16'h0000, carry: 1'b1};

      rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
      abort1 = 1'b0; in_valid1 = 1'b0; in_x1 = '0; in_y1 = '0; out_ready1 = 1'b0;
      prev_sum = 16'h0000;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_carry", 32'(out_carry), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_n1_in_ready", 32'(in_ready1), 32'd0);
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Table: constant expectations, cross-checked by the model in run_txn.
      for (int i = 0; i < 5; i++) begin
         run_txn(tbl[i].x, tbl[i].y, 0, (i == 2) ? 5 : 0, (i == 1));
         chk("tbl_sum", 32'(out_sum), 32'(tbl[i].sum));
         chk("tbl_carry", 32'(out_carry), 32'(tbl[i].carry));
      end

      // Abort after two nibbles, with in_valid high on the abort cycle.
      run_txn(16'hF97D, 16'h9F24, 0, 0, 1'b0);
      in_valid = 1'b1; in_x = 4'h5; in_y = 4'h6; step();
      in_x = 4'h7; in_y = 4'h8; step();
      abort = 1'b1; in_x = 4'h9; in_y = 4'h9; step();
      abort = 1'b0; in_valid = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_sum_kept", 32'(out_sum), 32'h98A1);
      chk("abort_carry_kept", 32'(out_carry), 32'd1);
      run_txn(16'h0001, 16'h0001, 0, 0, 1'b0);
      chk("after_abort_sum", 32'(out_sum), 32'h0002);

      // Reset after three accepted nibbles.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_x = 4'hA; in_y = 4'h7; step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_sum", 32'(out_sum), 32'd0);
      chk("midrst_out_carry", 32'(out_carry), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
      prev_sum = 16'h0000;
      run_txn(16'h1111, 16'h2222, 0, 0, 1'b0);
      chk("after_rst_sum", 32'(out_sum), 32'h3333);
      chk("after_rst_carry", 32'(out_carry), 32'd0);

      // Randomized transactions against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         run_txn(16'($urandom), 16'($urandom), 2, $urandom_range(0, 3), 1'b0);
      end

      // Single-nibble instance.
      run_txn1(4'hD, 4'h4);
      chk("n1_fixed_sum", 32'(out_sum1), 32'h1);
      for (int i = 0; i < 10; i++) begin
         run_txn1(4'($urandom), 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got stalled want finish");
      $fatal(1, "timeout");
   end

endmodule
